// File: rtl/fill_pkg.sv
// fill_pkg: shared pattern-mode and FSM-state encodings for the fill engine.
package fill_pkg;
  typedef enum logic [1:0] {
    MODE_SOLID,
    MODE_HSTRIPE,
    MODE_VSTRIPE,
    MODE_CHECK
  } mode_e;
  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_e;
endpackage

// File: rtl/pattern_colour.sv
// pattern_colour: combinational colour lookup for one pixel from its absolute x,y and the fill mode.
module pattern_colour
  import fill_pkg::*;
#(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int COLOUR_W     = 3,
  parameter int STRIPE_SHIFT = 3
) (
  input  mode_e               mode,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] fg,
  input  logic [COLOUR_W-1:0] bg,
  output logic [COLOUR_W-1:0] colour
);
  logic cx, cy, sel;
  assign cx = |((x >> STRIPE_SHIFT) & X_W'(1));
  assign cy = |((y >> STRIPE_SHIFT) & Y_W'(1));
  always_comb begin
    sel = mode == MODE_SOLID   ? 1'b1 :
          mode == MODE_HSTRIPE ? cy   :
          mode == MODE_VSTRIPE ? cx   : cx ^ cy;
  end
  assign colour = sel ? fg : bg;
endmodule

// File: rtl/fill_pattern_gen.sv
// fill_pattern_gen: rectangle fill rasteriser driving a VGA adapter, one pixel per clock.
// Define FILL_STALL_EN to add a ready input that holds the presented pixel until accepted.
module fill_pattern_gen
  import fill_pkg::*;
#(
  parameter int H_RES        = 160,
  parameter int V_RES        = 120,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int COLOUR_W     = 3,
  parameter int STRIPE_SHIFT = 3
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [COLOUR_W-1:0] fg,
  input  logic [COLOUR_W-1:0] bg,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
`ifdef FILL_STALL_EN
  input  logic                ready,
`endif
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_e              state_q, state_d;
  mode_e               mode_q, mode_d, pat_mode;
  logic [COLOUR_W-1:0] fg_q, fg_d, bg_q, bg_d, colour_q, colour_d;
  logic [COLOUR_W-1:0] pat_fg, pat_bg, pat_colour;
  logic [X_W-1:0]      x0_q, x0_d, x1_q, x1_d, x_q, x_d, nx;
  logic [Y_W-1:0]      y0_q, y0_d, y1_q, y1_d, y_q, y_d, ny;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                accept, region_ok, take, eol, last;
`ifdef FILL_STALL_EN
  assign take = plot_q && ready;
`else
  assign take = plot_q;
`endif
  assign accept    = start && state_q != DRAW;
  assign region_ok = x0 <= x1 && y0 <= y1 && 32'(x1) < H_RES && 32'(y1) < V_RES;
  assign eol       = x_q == x1_q;
  assign last      = eol && y_q == y1_q;
  // The next coordinate is either the new request's origin or the raster successor.
  assign nx       = accept ? x0 : eol ? x0_q : x_q + 1'b1;
  assign ny       = accept ? y0 : eol ? y_q + 1'b1 : y_q;
  assign pat_mode = accept ? mode_e'(mode) : mode_q;
  assign pat_fg   = accept ? fg : fg_q;
  assign pat_bg   = accept ? bg : bg_q;
  pattern_colour #(
    .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .STRIPE_SHIFT(STRIPE_SHIFT)
  ) u_pat (
    .mode(pat_mode), .x(nx), .y(ny), .fg(pat_fg), .bg(pat_bg), .colour(pat_colour)
  );
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = plot_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    if (accept) begin
      state_d  = region_ok ? DRAW : DONE;
      mode_d   = mode_e'(mode);
      fg_d     = fg;
      bg_d     = bg;
      x0_d     = x0;
      x1_d     = x1;
      y0_d     = y0;
      y1_d     = y1;
      x_d      = region_ok ? nx : x_q;
      y_d      = region_ok ? ny : y_q;
      colour_d = region_ok ? pat_colour : colour_q;
      plot_d   = region_ok;
      busy_d   = region_ok;
      done_d   = !region_ok;
      err_d    = !region_ok;
    end else if (state_q == DRAW && take) begin
      state_d  = last ? DONE : DRAW;
      x_d      = last ? x_q : nx;
      y_d      = last ? y_q : ny;
      colour_d = last ? colour_q : pat_colour;
      plot_d   = !last;
      busy_d   = !last;
      done_d   = last;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SOLID;
      fg_q     <= '0;
      bg_q     <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
endmodule

// File: tb/tb_fill_pattern_gen.sv
// tb_fill_pattern_gen: table, hand-written and random fills checked against a per-pixel reference list.
module tb_fill_pattern_gen;
`ifdef FILL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
  logic [1:0] mode = '0;
  logic [2:0] fg = '0, bg = '0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done, err;
  int compared = 0, mismatched = 0;
  typedef struct {int px; int py; int pc;} pix_t;
  typedef struct {
    logic [1:0] m;
    logic [2:0] f, b;
    logic [7:0] a0, a1;
    logic [6:0] b0, b1;
    int         npix;
    logic       e;
  } vec_t;
  pix_t exp_q[$];
  vec_t vt[9];
  always #5 clk = ~clk;
  fill_pattern_gen dut (
    .CLOCK_50(clk), .Reset(rst_n), .start(start), .mode(mode), .fg(fg), .bg(bg),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
`ifdef FILL_STALL_EN
    .ready(ready),
`endif
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done), .err(err)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  function automatic int ref_colour(input int m, input int f, input int b, input int xx, input int yy);
    int cx, cy;
    cx = (xx / 8) % 2;
    cy = (yy / 8) % 2;
    if (m == 0) return f;
    if (m == 1) return cy ? f : b;
    if (m == 2) return cx ? f : b;
    return (cx != cy) ? f : b;
  endfunction
  // stall_mode: 0 ready always high, 1 three-cycle stall from cycle 5, 2 random ready.
  task automatic fill(input string name, input vec_t v, input bit noise, input int stall_mode);
    bit ok;
    int n, cyc, stalls, budget;
    pix_t last_p;
    ok = v.a0 <= v.a1 && v.b0 <= v.b1 && v.a1 < 160 && v.b1 < 120;
    exp_q.delete();
    if (ok)
      for (int yy = v.b0; yy <= v.b1; yy++)
        for (int xx = v.a0; xx <= v.a1; xx++)
          exp_q.push_back('{xx, yy, ref_colour(v.m, v.f, v.b, xx, yy)});
    budget = exp_q.size() * 4 + 20;
    @(negedge clk);
    mode = v.m; fg = v.f; bg = v.b; x0 = v.a0; x1 = v.a1; y0 = v.b0; y1 = v.b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (ok) check({name, " first"}, {plot, busy, x, y}, {1'b1, 1'b1, v.a0, v.b0});
    else    check({name, " reject"}, {plot, busy, done, err}, 4'b0011);
    n = 0; cyc = 0; stalls = 0;
    while (!done && cyc < budget) begin
      if (plot) begin
        if (n < exp_q.size())
          check({name, " pixel"}, {x, y, colour}, {8'(exp_q[n].px), 7'(exp_q[n].py), 3'(exp_q[n].pc)});
        else
          check({name, " extra plot"}, 1, 0);
      end
      ready = !STALL || stall_mode == 0 ? 1'b1 :
              stall_mode == 1 ? !(cyc >= 5 && cyc < 8) : ($urandom % 4 != 0);
      if (plot && ready) n++;
      else if (plot) stalls++;
      start = noise && plot && ($urandom % 2 == 1);
      if (noise) begin
        mode = 2'($urandom); x0 = 8'($urandom_range(0, 50)); x1 = 8'($urandom_range(60, 150));
        y0 = 7'($urandom_range(0, 10)); y1 = 7'($urandom_range(20, 100));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    check({name, " count"}, n, v.npix);
    check({name, " cycles"}, cyc, v.npix + stalls);
    check({name, " done"}, {done, plot, busy, err}, {1'b1, 1'b0, 1'b0, v.e});
    if (ok) begin
      last_p = exp_q[exp_q.size() - 1];
      @(negedge clk);
      check({name, " hold"}, {done, plot, x, y, colour},
            {1'b1, 1'b0, 8'(last_p.px), 7'(last_p.py), 3'(last_p.pc)});
    end
  endtask
  initial begin
    vec_t rv;
    int xa, xb, ya, yb;
    vt[0] = '{2'd0, 3'b101, 3'd2, 8'd0,   8'd159, 7'd0,   7'd119, 19200, 1'b0};
    vt[1] = '{2'd2, 3'd7,   3'd0, 8'd10,  8'd12,  7'd5,   7'd6,   6,     1'b0};
    vt[2] = '{2'd1, 3'd3,   3'd4, 8'd20,  8'd19,  7'd0,   7'd3,   0,     1'b1};
    vt[3] = '{2'd1, 3'd6,   3'd1, 8'd3,   8'd5,   7'd7,   7'd8,   6,     1'b0};
    vt[4] = '{2'd3, 3'd4,   3'd3, 8'd159, 8'd159, 7'd119, 7'd119, 1,     1'b0};
    vt[5] = '{2'd0, 3'd1,   3'd2, 8'd150, 8'd160, 7'd0,   7'd0,   0,     1'b1};
    vt[6] = '{2'd0, 3'd1,   3'd2, 8'd0,   8'd3,   7'd5,   7'd4,   0,     1'b1};
    vt[7] = '{2'd0, 3'd1,   3'd2, 8'd0,   8'd3,   7'd100, 7'd120, 0,     1'b1};
    vt[8] = '{2'd3, 3'd5,   3'd2, 8'd6,   8'd9,   7'd6,   7'd9,   16,    1'b0};
    #12;
    check("reset state", {x, y, colour, plot, busy, done, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) fill($sformatf("vec%0d", i), vt[i], 1'b0, 0);
    // Reset lands on the 50th DRAW cycle of a large fill.
    @(negedge clk);
    mode = 2'd3; fg = 3'd6; bg = 3'd1; x0 = 8'd0; x1 = 8'd159; y0 = 7'd0; y1 = 7'd119; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("pre-reset x", {plot, x}, {1'b1, 8'd49});
    rst_n = 1'b0;
    #1;
    check("mid reset", {x, y, colour, plot, busy, done, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    fill("after reset", '{2'd2, 3'd5, 3'd2, 8'd30, 8'd41, 7'd2, 7'd3, 24, 1'b0}, 1'b0, 0);
    fill("start noise", '{2'd1, 3'd7, 3'd1, 8'd0, 8'd19, 7'd6, 7'd9, 80, 1'b0}, 1'b1, 0);
    fill("back to back", '{2'd3, 3'd2, 3'd5, 8'd100, 8'd101, 7'd50, 7'd50, 2, 1'b0}, 1'b0, 0);
    fill("stall", '{2'd2, 3'd3, 3'd4, 8'd4, 8'd19, 7'd0, 7'd1, 32, 1'b0}, 1'b0, 1);
    for (int i = 0; i < 30; i++) begin
      xa = $urandom_range(0, 170);
      xb = ($urandom % 6 == 0) ? $urandom_range(0, 170) : xa + $urandom_range(0, 10);
      ya = $urandom_range(0, 122);
      yb = ($urandom % 6 == 0) ? $urandom_range(0, 122) : ya + $urandom_range(0, 5);
      if (yb > 127) yb = 127;
      rv.m = 2'($urandom); rv.f = 3'($urandom); rv.b = 3'($urandom);
      rv.a0 = 8'(xa); rv.a1 = 8'(xb); rv.b0 = 7'(ya); rv.b1 = 7'(yb);
      rv.e = !(xa <= xb && ya <= yb && xb < 160 && yb < 120);
      rv.npix = rv.e ? 0 : (xb - xa + 1) * (yb - ya + 1);
      fill($sformatf("rand%0d", i), rv, ($urandom % 3 == 0), 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
